frame_demux_1in4out: RTL and testbench

FRAME_DEMUX_1IN4OUT -- requirements
Module: frame_demux_1in4out

---
 rtl/frame_demux_1in4out_pkg.sv | 23 ++
 rtl/frame_chan_reg.sv | 54 +++++
 rtl/frame_demux_1in4out.sv | 74 +++++++
 tb/tb_frame_demux_1in4out.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_demux_1in4out_pkg.sv
// Shared definitions for the 1-to-4 frame demultiplexer: default widths,
// channel count, channel-index type and the index-to-one-hot decode.
package frame_demux_1in4out_pkg;

  localparam int WIDTH_DEF = 40;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_CH    = 4;

  typedef logic [1:0] chan_idx_t;

  function automatic logic [NUM_CH-1:0] chan_onehot(input chan_idx_t idx);
    logic [NUM_CH-1:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/frame_chan_reg.sv
// One output channel: held frame, one-cycle update pulse and a dirty flag
// that is set by a write and cleared by the consumer's acknowledge.
module frame_chan_reg
  import frame_demux_1in4out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             upd,
  output logic             dirty
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             upd_q, upd_d;
  logic             dirty_q, dirty_d;

  // Next-state: a write in the same cycle as ack keeps the channel dirty.
  always_comb begin
    data_d  = data_q;
    upd_d   = wr_en;
    dirty_d = dirty_q;
    if (wr_en) begin
      data_d  = wr_data;
      dirty_d = 1'b1;
    end else if (ack) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      upd_q   <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      upd_q   <= upd_d;
      dirty_q <= dirty_d;
    end
  end

  assign data  = data_q;
  assign upd   = upd_q;
  assign dirty = dirty_q;

endmodule

// File: rtl/frame_demux_1in4out.sv
// Routes one input frame per cycle to one of four held output channels,
// honouring per-channel write locks and counting accepted frames.
module frame_demux_1in4out
  import frame_demux_1in4out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        lock,
  input  logic [3:0]        ack,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [3:0]        upd,
  output logic [3:0]        dirty,
  output logic [CNT_W-1:0]  frame_cnt
);

  logic              xfer_s;
  logic [3:0]        wr_vec_s;
  logic [WIDTH-1:0]  out_arr [NUM_CH];
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  // Ready depends only on the lock of the addressed channel, never on valid.
  always_comb begin
    in_ready    = ~lock[in_sel];
    xfer_s      = in_valid & in_ready;
    wr_vec_s    = 4'b0000;
    frame_cnt_d = frame_cnt_q;
    if (xfer_s) begin
      wr_vec_s    = chan_onehot(chan_idx_t'(in_sel));
      frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wr_vec_s    = 4'b0000;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Accepted-frame counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    frame_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_vec_s[g]),
      .wr_data (in_data),
      .ack     (ack[g]),
      .data    (out_arr[g]),
      .upd     (upd[g]),
      .dirty   (dirty[g])
    );
  end

  assign out0      = out_arr[0];
  assign out1      = out_arr[1];
  assign out2      = out_arr[2];
  assign out3      = out_arr[3];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_demux_1in4out.sv
// Self-checking bench for frame_demux_1in4out: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_frame_demux_1in4out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic [39:0] out0, out1, out2, out3;
  logic [3:0]  upd;
  logic [3:0]  dirty;
  logic [7:0]  frame_cnt;

  int tests  = 0;
  int failed = 0;

  frame_demux_1in4out #(.WIDTH(40), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lock      (lock),
    .ack       (ack),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .upd       (upd),
    .dirty     (dirty),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [39:0] data;
    logic        valid;
    logic [3:0]  lock;
    logic [3:0]  ack;
    logic        e_rdy;
    logic [39:0] e0, e1, e2, e3;
    logic [3:0]  e_upd;
    logic [3:0]  e_dirty;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [1:0] sel, input logic [39:0] data, input logic valid,
                         input logic [3:0] lk, input logic [3:0] ak, input logic e_rdy,
                         input logic [39:0] e0, input logic [39:0] e1, input logic [39:0] e2,
                         input logic [39:0] e3, input logic [3:0] e_upd, input logic [3:0] e_dirty,
                         input logic [7:0] e_cnt);
    vec_t v;
    v.sel = sel; v.data = data; v.valid = valid; v.lock = lk; v.ack = ak; v.e_rdy = e_rdy;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    v.e_upd = e_upd; v.e_dirty = e_dirty; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [39:0] e0, input logic [39:0] e1,
                         input logic [39:0] e2, input logic [39:0] e3, input logic [3:0] e_upd,
                         input logic [3:0] e_dirty, input logic [7:0] e_cnt);
    chk({tag, ".out0"}, 64'(out0), 64'(e0));
    chk({tag, ".out1"}, 64'(out1), 64'(e1));
    chk({tag, ".out2"}, 64'(out2), 64'(e2));
    chk({tag, ".out3"}, 64'(out3), 64'(e3));
    chk({tag, ".upd"}, 64'(upd), 64'(e_upd));
    chk({tag, ".dirty"}, 64'(dirty), 64'(e_dirty));
    chk({tag, ".cnt"}, 64'(frame_cnt), 64'(e_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_sel = 2'd0; in_data = 40'd0; lock = 4'd0; ack = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: per-channel contents, computed from the routing rules.
  logic [39:0] m_out [4];
  logic [3:0]  m_dirty;
  logic [3:0]  m_upd;
  int          m_cnt;

  initial begin
    logic [39:0] d;
    logic        e_rdy;
    logic        xfer;

    rst_n = 1'b1;
    idle_in();
    #2;
    rst_n = 1'b0;
    #20;
    chk_all("reset", 40'd0, 40'd0, 40'd0, 40'd0, 4'd0, 4'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: first write, back-to-back one-hot, ack/write collision, lock.
    add_vec(2'd2, 40'hA5A5A5A5A5, 1'b1, 4'b0000, 4'b0000, 1'b1,
            40'd0, 40'd0, 40'hA5A5A5A5A5, 40'd0, 4'b0100, 4'b0100, 8'd1);
    add_vec(2'd0, 40'd1, 1'b1, 4'b0000, 4'b0000, 1'b1,
            40'd1, 40'd0, 40'hA5A5A5A5A5, 40'd0, 4'b0001, 4'b0101, 8'd2);
    add_vec(2'd1, 40'd2, 1'b1, 4'b0000, 4'b0000, 1'b1,
            40'd1, 40'd2, 40'hA5A5A5A5A5, 40'd0, 4'b0010, 4'b0111, 8'd3);
    add_vec(2'd2, 40'd3, 1'b1, 4'b0000, 4'b0000, 1'b1,
            40'd1, 40'd2, 40'd3, 40'd0, 4'b0100, 4'b0111, 8'd4);
    add_vec(2'd3, 40'd4, 1'b1, 4'b0000, 4'b0000, 1'b1,
            40'd1, 40'd2, 40'd3, 40'd4, 4'b1000, 4'b1111, 8'd5);
    add_vec(2'd1, 40'd5, 1'b1, 4'b0000, 4'b0010, 1'b1,
            40'd1, 40'd5, 40'd3, 40'd4, 4'b0010, 4'b1111, 8'd6);
    add_vec(2'd1, 40'd6, 1'b0, 4'b0000, 4'b0010, 1'b1,
            40'd1, 40'd5, 40'd3, 40'd4, 4'b0000, 4'b1101, 8'd6);
    add_vec(2'd1, 40'd7, 1'b0, 4'b0000, 4'b0010, 1'b1,
            40'd1, 40'd5, 40'd3, 40'd4, 4'b0000, 4'b1101, 8'd6);
    add_vec(2'd3, 40'd9, 1'b1, 4'b1000, 4'b0000, 1'b0,
            40'd1, 40'd5, 40'd3, 40'd4, 4'b0000, 4'b1101, 8'd6);
    add_vec(2'd0, 40'd7, 1'b1, 4'b1000, 4'b1101, 1'b1,
            40'd7, 40'd5, 40'd3, 40'd4, 4'b0001, 4'b0001, 8'd7);

    foreach (tbl[i]) begin
      in_sel = tbl[i].sel; in_data = tbl[i].data; in_valid = tbl[i].valid;
      lock = tbl[i].lock; ack = tbl[i].ack;
      #1;
      chk($sformatf("vec%0d.ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3,
              tbl[i].e_upd, tbl[i].e_dirty, tbl[i].e_cnt);
    end

    // Asynchronous reset between edges, held across an edge with a pending transfer.
    @(negedge clk);
    in_sel = 2'd1; in_data = 40'hFFFF; in_valid = 1'b1; lock = 4'b0010; ack = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 40'd0, 40'd0, 40'd0, 40'd0, 4'd0, 4'd0, 8'd0);
    chk("rst_ready_locked", 64'(in_ready), 64'd0);
    lock = 4'b0000;
    #1;
    chk("rst_ready_open", 64'(in_ready), 64'd1);
    tick();
    chk_all("rst_edge", 40'd0, 40'd0, 40'd0, 40'd0, 4'd0, 4'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("post_rst", 40'd0, 40'hFFFF, 40'd0, 40'd0, 4'b0010, 4'b0010, 8'd1);

    // Stall on a locked channel while data changes; last data wins on release.
    do_reset();
    lock = 4'b0001; in_sel = 2'd0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 40'h100 + 40'(k);
      #1;
      chk($sformatf("stall%0d.ready", k), 64'(in_ready), 64'd0);
      tick();
      chk_all($sformatf("stall%0d", k), 40'd0, 40'd0, 40'd0, 40'd0, 4'd0, 4'd0, 8'd0);
    end
    lock = 4'b0000; in_data = 40'h1234567890;
    #1;
    chk("release.ready", 64'(in_ready), 64'd1);
    tick();
    chk_all("release", 40'h1234567890, 40'd0, 40'd0, 40'd0, 4'b0001, 4'b0001, 8'd1);
    in_valid = 1'b0;
    tick();
    chk_all("release_idle", 40'h1234567890, 40'd0, 40'd0, 40'd0, 4'b0000, 4'b0001, 8'd1);

    // Counter wrap after 256 accepted frames.
    do_reset();
    in_valid = 1'b1; lock = 4'b0000;
    for (int k = 0; k < 255; k++) begin
      in_sel = 2'($urandom_range(0, 3));
      in_data = 40'(k);
      tick();
    end
    chk("wrap.255", 64'(frame_cnt), 64'd255);
    tick();
    chk("wrap.0", 64'(frame_cnt), 64'd0);
    in_valid = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 4; n++) m_out[n] = 40'd0;
    m_dirty = 4'd0; m_upd = 4'd0; m_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      d = {8'($urandom), 32'($urandom)};
      in_data = d;
      in_sel = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      ack = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      #1;
      e_rdy = !lock[in_sel];
      xfer = in_valid && e_rdy;
      chk($sformatf("rnd%0d.ready", k), 64'(in_ready), 64'(e_rdy));
      for (int n = 0; n < 4; n++) begin
        if (xfer && in_sel == 2'(n)) begin
          m_out[n] = d;
          m_dirty[n] = 1'b1;
        end else if (ack[n]) begin
          m_dirty[n] = 1'b0;
        end
      end
      m_upd = xfer ? (4'b0001 << in_sel) : 4'b0000;
      m_cnt = (m_cnt + (xfer ? 1 : 0)) % 256;
      tick();
      chk_all($sformatf("rnd%0d", k), m_out[0], m_out[1], m_out[2], m_out[3],
              m_upd, m_dirty, 8'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
